// File: rtl/router_port_buffer_pkg.sv
// router_port_buffer_pkg: shared framing state type and port index constants for the router input buffer.
package router_port_buffer_pkg;

    typedef enum logic [1:0] {FR_HEADER, FR_SIZE, FR_PAYLOAD} frame_state_t;

    localparam int PORT_EAST  = 0;
    localparam int PORT_WEST  = 1;
    localparam int PORT_NORTH = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_LOCAL = 4;

endpackage

// File: rtl/router_port_fifo.sv
// router_port_fifo: one link channel with show-ahead FIFO, credit flow control,
// sticky overflow flag and output-side packet framing tracker.
module router_port_fifo
    import router_port_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int CW        = $clog2(DEPTH) + 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic                  tx_o,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic [CW-1:0]         occupancy_o,
    output logic                  overflow_o
);

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q;
    frame_state_t          state_q, state_d;
    logic [FLIT_WIDTH-1:0] rem_q, rem_d;
    logic                  wr, rd;

    assign credit_o    = count_q < CW'(DEPTH);
    assign tx_o        = count_q != '0;
    assign data_o      = tx_o ? mem_q[rd_ptr_q] : '0;
    assign occupancy_o = count_q;
    assign overflow_o  = overflow_q;
    assign wr          = rx_i && credit_o;
    assign rd          = tx_o && credit_i;
    assign count_d     = count_q + CW'(wr) - CW'(rd);

    assign sop_o = tx_o && state_q == FR_HEADER;
    assign eop_o = tx_o && ((state_q == FR_SIZE && data_o == '0) ||
                            (state_q == FR_PAYLOAD && rem_q == FLIT_WIDTH'(1)));

    // Framing only advances when a flit actually leaves toward the switch
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (rd) begin
            case (state_q)
                FR_HEADER: state_d = FR_SIZE;
                FR_SIZE: begin
                    rem_d   = data_o;
                    state_d = data_o == '0 ? FR_HEADER : FR_PAYLOAD;
                end
                FR_PAYLOAD: begin
                    rem_d   = rem_q - FLIT_WIDTH'(1);
                    state_d = rem_q == FLIT_WIDTH'(1) ? FR_HEADER : FR_PAYLOAD;
                end
                default: state_d = FR_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= FR_HEADER;
            rem_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(wr);
            rd_ptr_q   <= rd_ptr_q + AW'(rd);
            count_q    <= count_d;
            overflow_q <= overflow_q | (rx_i & ~credit_o);
            state_q    <= state_d;
            rem_q      <= rem_d;
        end
    end

endmodule

// File: rtl/router_port_buffer.sv
// router_port_buffer: NUM_PORTS independent credit-controlled input channels
// between the link pins and the router switch.
module router_port_buffer
    import router_port_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_PORTS  = 5,
    parameter int DEPTH      = 8,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            rx,
    input  logic [FLIT_WIDTH*NUM_PORTS-1:0] data_i,
    output logic [NUM_PORTS-1:0]            credit_o,
    output logic [NUM_PORTS-1:0]            tx,
    output logic [FLIT_WIDTH*NUM_PORTS-1:0] data_o,
    input  logic [NUM_PORTS-1:0]            credit_i,
    output logic [NUM_PORTS-1:0]            sop_o,
    output logic [NUM_PORTS-1:0]            eop_o,
    output logic [CW*NUM_PORTS-1:0]         occupancy_o,
    output logic [NUM_PORTS-1:0]            overflow_o
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_port_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .rx_i       (rx[p]),
            .data_i     (data_i[p*FLIT_WIDTH +: FLIT_WIDTH]),
            .credit_o   (credit_o[p]),
            .tx_o       (tx[p]),
            .data_o     (data_o[p*FLIT_WIDTH +: FLIT_WIDTH]),
            .credit_i   (credit_i[p]),
            .sop_o      (sop_o[p]),
            .eop_o      (eop_o[p]),
            .occupancy_o(occupancy_o[p*CW +: CW]),
            .overflow_o (overflow_o[p])
        );
    end

endmodule

// File: tb/tb_router_port_buffer.sv
// tb_router_port_buffer: directed-vector self-checking bench for router_port_buffer.
module tb_router_port_buffer;

    localparam int FW = 32;
    localparam int NP = 5;
    localparam int DEPTH = 8;
    localparam int CW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     rx = '0;
    logic [FW*NP-1:0]  data_i = '0;
    logic [NP-1:0]     credit_o;
    logic [NP-1:0]     tx;
    logic [FW*NP-1:0]  data_o;
    logic [NP-1:0]     credit_i = '0;
    logic [NP-1:0]     sop_o;
    logic [NP-1:0]     eop_o;
    logic [CW*NP-1:0]  occupancy_o;
    logic [NP-1:0]     overflow_o;

    int errors = 0;
    int checks = 0;

    router_port_buffer #(.FLIT_WIDTH(FW), .NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
        .tx(tx), .data_o(data_o), .credit_i(credit_i), .sop_o(sop_o), .eop_o(eop_o),
        .occupancy_o(occupancy_o), .overflow_o(overflow_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [FW-1:0] dout(input int p);
        return data_o[p*FW +: FW];
    endfunction

    function automatic logic [CW-1:0] occ(input int p);
        return occupancy_o[p*CW +: CW];
    endfunction

    logic [FW-1:0] pkt0 [4] = '{32'h11, 32'h2, 32'hA, 32'hB};
    logic [FW-1:0] pkt4 [4] = '{32'h44, 32'h0, 32'h55, 32'h0};
    logic          sop4 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic          eop4 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // reset state
        #2;
        check("rst_credit", credit_o, 5'h1F);
        check("rst_tx", tx, 0);
        check("rst_occ", occupancy_o, 0);
        #10 reset = 1'b1;
        tick();
        tick();
        check("idle_credit", credit_o, 5'h1F);
        check("idle_tx", tx, 0);
        check("idle_sop", sop_o, 0);
        check("idle_eop", eop_o, 0);
        check("idle_ovf", overflow_o, 0);
        check("idle_occ", occupancy_o, 0);
        check("idle_data", data_o, 0);

        // channel 0 back-to-back packet
        credit_i = '1;
        for (int i = 0; i < 4; i++) begin
            rx[0] = 1'b1;
            data_i[0 +: FW] = pkt0[i];
            tick();
            check("c0_tx", tx[0], 1);
            check("c0_data", dout(0), pkt0[i]);
            check("c0_sop", sop_o[0], i == 0);
            check("c0_eop", eop_o[0], i == 3);
            check("c0_occ", occ(0), 1);
        end
        rx[0] = 1'b0;
        tick();
        check("c0_tx_end", tx[0], 0);

        // channel 2 fill to overflow with no switch credit
        credit_i = '0;
        for (int i = 0; i < 9; i++) begin
            check("c2_credit", credit_o[2], i < 8);
            rx[2] = 1'b1;
            data_i[2*FW +: FW] = 32'h100 + i;
            tick();
        end
        rx[2] = 1'b0;
        check("c2_ovf", overflow_o, 5'b00100);
        check("c2_occ_full", occ(2), 8);
        check("c2_credit_full", credit_o[2], 0);
        check("c2_sop_hold", sop_o[2], 1);
        credit_i[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("c2_drain_tx", tx[2], 1);
            check("c2_drain_data", dout(2), 32'h100 + k);
            tick();
        end
        check("c2_empty_tx", tx[2], 0);
        check("c2_empty_credit", credit_o[2], 1);
        check("c2_ovf_sticky", overflow_o[2], 1);

        // channel 4 size-zero packet followed by another header
        credit_i = '1;
        for (int i = 0; i < 4; i++) begin
            rx[4] = 1'b1;
            data_i[4*FW +: FW] = pkt4[i];
            tick();
            check("c4_data", dout(4), pkt4[i]);
            check("c4_sop", sop_o[4], sop4[i]);
            check("c4_eop", eop_o[4], eop4[i]);
        end
        rx[4] = 1'b0;
        tick();

        // all ports at full rate, 64 flits each
        for (int i = 0; i < 64; i++) begin
            rx = '1;
            for (int p = 0; p < NP; p++) data_i[p*FW +: FW] = 32'h5000_0000 | (p << 16) | i;
            tick();
            for (int p = 0; p < NP; p++) begin
                check("all_data", dout(p), 32'h5000_0000 | (p << 16) | i);
                check("all_occ", occ(p), 1);
            end
        end
        rx = '0;
        tick();
        check("all_tx_end", tx, 0);
        check("all_ovf", overflow_o, 5'b00100);

        // reset mid-payload on channel 1
        credit_i[1] = 1'b1;
        rx[1] = 1'b1;
        data_i[FW +: FW] = 32'h77;
        tick();
        data_i[FW +: FW] = 32'h5;
        tick();
        data_i[FW +: FW] = 32'h1;
        tick();
        credit_i[1] = 1'b0;
        data_i[FW +: FW] = 32'h2;
        tick();
        data_i[FW +: FW] = 32'h3;
        tick();
        rx[1] = 1'b0;
        check("c1_occ3", occ(1), 3);
        check("c1_sop_mid", sop_o[1], 0);
        reset = 1'b0;
        #1;
        check("c1_rst_tx", tx[1], 0);
        check("c1_rst_occ", occ(1), 0);
        check("c1_rst_data", dout(1), 0);
        check("c1_rst_ovf", overflow_o, 0);
        #2 reset = 1'b1;
        tick();
        credit_i[1] = 1'b1;
        rx[1] = 1'b1;
        data_i[FW +: FW] = 32'h99;
        tick();
        rx[1] = 1'b0;
        check("c1_hdr_data", dout(1), 32'h99);
        check("c1_hdr_sop", sop_o[1], 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_port_buffer.md
Name: router_port_buffer

Overview:
- Parametrised input-buffering stage for the mesh router's NUM_PORTS link channels; sits between the link-level rx/data_i/credit_o pins and the router switch.
- Each channel has an independent DEPTH-flit FIFO, credit-based flow control on both sides, and output-side packet framing tracking (header, size, payload).
- Framing drives start-of-packet and end-of-packet flags aligned to data_o.
- Replaces per-link dual-clock wiring with a single clock domain.

Parameters:
- FLIT_WIDTH, 32: bits per flit.
- NUM_PORTS, 5: number of link channels. Index 0..4 = EAST, WEST, NORTH, SOUTH, LOCAL when 5.
- DEPTH, 8: flits per channel FIFO. Power of two, >= 2.
- CW, $clog2(DEPTH)+1: occupancy counter width (derived, localparam).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  NUM_PORTS  flit valid from upstream link, per channel.
- data_i  in  FLIT_WIDTH*NUM_PORTS  upstream flits; channel p at [p*FLIT_WIDTH +: FLIT_WIDTH].
- credit_o  out  NUM_PORTS  1 = channel p can accept a flit this cycle.
- tx  out  NUM_PORTS  flit valid toward switch.
- data_o  out  FLIT_WIDTH*NUM_PORTS  head flit of each FIFO, same slicing as data_i.
- credit_i  in  NUM_PORTS  1 = switch accepts channel p's flit this cycle.
- sop_o  out  NUM_PORTS  data_o[p] is a header flit (valid only with tx[p]).
- eop_o  out  NUM_PORTS  data_o[p] is the last flit of its packet (valid only with tx[p]).
- occupancy_o  out  CW*NUM_PORTS  flits held per channel.
- overflow_o  out  NUM_PORTS  sticky: rx seen while credit_o was 0.

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers and counts go to 0.
  - credit_o = all 1; tx, sop_o, eop_o, overflow_o = 0; occupancy_o = 0.
  - data_o = 0 while empty.
  - Framing state = HEADER.
  - Deassertion is synchronous to clock.
- Write: on an edge with rx[p] && credit_o[p], data_i slice is stored at the write pointer and the pointer increments.
- Credit: credit_o[p] = (count < DEPTH), combinational from registered count.
- Read: tx[p] = (count != 0); data_o[p] = mem[rd_ptr] (show-ahead). On an edge with tx[p] && credit_i[p], rd_ptr increments.
- Latency: a flit written at edge N appears on data_o with tx at edge N+1. No bypass when empty.
- Simultaneous read and write: count is unchanged; both pointers advance.
  - When full, credit_o=0, so no write occurs; a read frees a slot, visible as credit_o=1 next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Overflow: rx[p] while credit_o[p]=0 drops the flit. FIFO is unchanged; overflow_o[p] sets and holds until reset.
- Framing FSM per channel, advancing only on an output transfer (tx && credit_i):
  - HEADER -> SIZE.
  - SIZE: load remaining = data_o[FLIT_WIDTH-1:0]. If zero -> HEADER, else -> PAYLOAD.
  - PAYLOAD: decrement remaining; when remaining==1 -> HEADER.
  - remaining is FLIT_WIDTH bits; no saturation is needed because it decrements only from nonzero.
- sop_o[p] = tx[p] && state==HEADER.
- eop_o[p] = tx[p] && ((state==SIZE && data_o==0) || (state==PAYLOAD && remaining==1)).
- While tx=0, sop_o and eop_o are 0 and the FSM holds state.
- Channels are fully independent; no shared arbitration.
- Reset mid-packet discards all buffered flits, and framing restarts at HEADER.

Decomposition:
- defs package additions:
  - typedef enum logic[1:0] {FR_HEADER, FR_SIZE, FR_PAYLOAD} frame_state_t.
  - Port index constants PORT_EAST..PORT_LOCAL.
- Sub-module router_port_fifo: one channel holding the FIFO, count, credit, overflow and framing FSM.
- Top-level generate loop instantiates NUM_PORTS copies and slices the buses.

Test Plan:
- Reset then idle: all credit_o=1; tx, sop_o, eop_o, overflow_o = 0; occupancy 0 on every channel.
- Channel 0, credit_i=1, inject header 0x0000_0011, size 0x2, payloads 0xA, 0xB back-to-back:
  - tx follows rx by one cycle.
  - sop_o on the 0x11 cycle, eop_o on the 0xB cycle.
  - Order preserved.
- Channel 2, credit_i=0, inject 9 flits with DEPTH=8:
  - credit_o drops after the 8th write; the 9th is dropped and overflow_o[2]=1.
  - Raise credit_i: 8 flits drain in order, then credit_o=1.
- Size-zero packet (header, 0x0) on channel 4: eop_o asserted on the size flit; next flit flagged sop_o.
- Concurrent full-rate rx and credit_i on all 5 ports for 64 flits: no drops, occupancy steady at 1, per-channel ordering and wrap-around correct.
- Assert reset mid-payload on channel 1 with 3 flits buffered: immediate tx=0 and occupancy 0; next flit after release is treated as a header (sop_o=1).
